// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Keeps the in-flight control-flow instructions between fetch and execute.
// Fetch pushes one record per predicted branch. Execute resolves the oldest
// record. Each resolution produces a one-cycle predictor update strobe. When
// the branch was mispredicted, the queue also raises a timed pipeline flush
// that carries the correct fetch PC.
//
// Optional feature: define BRQ_TARGET_CHECK_EN to store predicted targets.
// A taken-predicted branch that resolves taken to a different target then
// also counts as a mispredict. Without the macro only the direction is
// compared, and push_target is not stored.
//
// Parameters
//   DEPTH         number of record entries (power of two, 2..16)
//   FLUSH_CYCLES  cycles that flush stays high after a mispredict (>= 1)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   push          fetch-side record valid
//   push_pc       fetch PC of the control-flow instruction
//   push_pred     predicted taken
//   push_target   predicted target
//   resolve       execute-side resolution of the oldest record
//   res_taken     actual direction
//   res_target    actual target
//   res_is_cond   resolved instruction is a conditional branch
//   full, empty   queue status
//   count         occupied entries
//   upd_valid     one-cycle predictor update strobe (one cycle after a pop)
//   upd_addr      stored pc[9:2] of the resolved branch
//   upd_taken     resolved direction
//   upd_is_cond   resolved instruction is a conditional branch
//   flush         pipeline flush, high for FLUSH_CYCLES cycles
//   redirect_pc   correct fetch PC, valid while flush is high
//   err           sticky overflow/underflow indicator
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [31:0]            push_pc,
  input  logic                   push_pred,
  input  logic [31:0]            push_target,
  input  logic                   resolve,
  input  logic                   res_taken,
  input  logic [31:0]            res_target,
  input  logic                   res_is_cond,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   upd_valid,
  output logic [7:0]             upd_addr,
  output logic                   upd_taken,
  output logic                   upd_is_cond,
  output logic                   flush,
  output logic [31:0]            redirect_pc,
  output logic                   err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [CW-1:0]  DEPTH_C      = CW'(DEPTH);
  localparam logic [FCW-1:0] FLUSH_LAST_C = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t         state;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [FCW-1:0] flush_cnt;

  // Record storage, one array per field.
  logic [31:0] pc_mem   [DEPTH];
  logic        pred_mem [DEPTH];
`ifdef BRQ_TARGET_CHECK_EN
  logic [31:0] target_mem [DEPTH];
`endif

  // Head of the queue, read combinationally.
  logic [31:0] head_pc;
  logic        head_pred;
`ifdef BRQ_TARGET_CHECK_EN
  logic [31:0] head_target;
`endif

  logic run;
  logic pop_ok;
  logic push_ok;
  logic mispredict;
  logic overflow;
  logic underflow;
  logic [31:0] redirect_next;

`ifndef BRQ_TARGET_CHECK_EN
  // The predicted target is not needed when only direction is compared.
  logic unused_target;
  assign unused_target = ^push_target;
`endif

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign head_pc   = pc_mem[rd_ptr];
  assign head_pred = pred_mem[rd_ptr];
`ifdef BRQ_TARGET_CHECK_EN
  assign head_target = target_mem[rd_ptr];
`endif

  // NOTE: every signal written in always_comb gets a default value first.
  // A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    run        = 1'b0;
    pop_ok     = 1'b0;
    push_ok    = 1'b0;
    mispredict = 1'b0;
    overflow   = 1'b0;
    underflow  = 1'b0;

    run    = (state == ST_RUN);
    pop_ok = run && resolve && !empty;
    // A push into a full queue is accepted when the head leaves in the
    // same cycle. The freed slot is the one being written.
    push_ok   = run && push && (!full || pop_ok);
    overflow  = run && push && full && !pop_ok;
    underflow = run && resolve && empty;

    mispredict = (head_pred != res_taken);
`ifdef BRQ_TARGET_CHECK_EN
    mispredict = mispredict ||
                 (res_taken && head_pred && (head_target != res_target));
`endif
  end

  assign redirect_next = res_taken ? res_target : (head_pc + 32'd4);

  // NOTE: the record arrays have no reset. Their contents are never read
  // while count is zero, so a reset would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr]   <= push_pc;
      pred_mem[wr_ptr] <= push_pred;
`ifdef BRQ_TARGET_CHECK_EN
      target_mem[wr_ptr] <= push_target;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      flush_cnt   <= '0;
      upd_valid   <= 1'b0;
      upd_addr    <= '0;
      upd_taken   <= 1'b0;
      upd_is_cond <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      err         <= 1'b0;
    end else begin
      // The predictor update follows every real pop, mispredicted or not.
      upd_valid <= pop_ok;
      if (pop_ok) begin
        upd_addr    <= head_pc[9:2];
        upd_taken   <= res_taken;
        upd_is_cond <= res_is_cond;
      end

      if (overflow || underflow) begin
        err <= 1'b1;
      end

      case (state)
        ST_RUN: begin
          if (pop_ok && mispredict) begin
            // Every younger record is on the wrong path, so drop them all.
            // A push in this same cycle is also dropped.
            state       <= ST_FLUSH;
            flush       <= 1'b1;
            flush_cnt   <= FLUSH_LAST_C;
            redirect_pc <= redirect_next;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
          end else begin
            if (push_ok) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
              count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
              count <= count - 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          // flush_cnt counts the remaining cycles after this one.
          if (flush_cnt == '0) begin
            state <= ST_RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Self-checking bench for branch_resolve_queue with the default parameters
// (DEPTH=4, FLUSH_CYCLES=2). It applies directed scenarios and then a random
// phase. A queue-based reference model predicts every output. The bench
// follows BRQ_TARGET_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk;
  logic        rst;
  logic        push;
  logic [31:0] push_pc;
  logic        push_pred;
  logic [31:0] push_target;
  logic        resolve;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_is_cond;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        upd_valid;
  logic [7:0]  upd_addr;
  logic        upd_taken;
  logic        upd_is_cond;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        err;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue #(
    .DEPTH       (DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (push_pc),
    .push_pred  (push_pred),
    .push_target(push_target),
    .resolve    (resolve),
    .res_taken  (res_taken),
    .res_target (res_target),
    .res_is_cond(res_is_cond),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .upd_valid  (upd_valid),
    .upd_addr   (upd_addr),
    .upd_taken  (upd_taken),
    .upd_is_cond(upd_is_cond),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list of branch records plus a flush timer.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } rec_t;

  rec_t        mq[$];
  int          m_flush_left;
  logic [31:0] m_redirect;
  logic        m_err;
  logic        m_upd_valid;
  logic [7:0]  m_upd_addr;
  logic        m_upd_taken;
  logic        m_upd_cond;

  task automatic model_reset();
    mq.delete();
    m_flush_left = 0;
    m_redirect   = '0;
    m_err        = 1'b0;
    m_upd_valid  = 1'b0;
    m_upd_addr   = '0;
    m_upd_taken  = 1'b0;
    m_upd_cond   = 1'b0;
  endtask

  // Applies one clock edge worth of inputs to the model.
  task automatic model_step(input logic p, input logic [31:0] ppc,
                            input logic ppred, input logic [31:0] ptgt,
                            input logic r, input logic rt,
                            input logic [31:0] rtgt, input logic rc);
    bit   do_pop;
    bit   do_push;
    bit   mis;
    rec_t head;
    rec_t nrec;
    m_upd_valid = 1'b0;
    if (m_flush_left > 0) begin
      // The flush window ignores all traffic.
      m_flush_left--;
      return;
    end
    do_pop  = r && (mq.size() > 0);
    do_push = p && ((mq.size() < DEPTH) || do_pop);
    if (r && mq.size() == 0) m_err = 1'b1;
    if (p && mq.size() == DEPTH && !do_pop) m_err = 1'b1;
    if (do_pop) begin
      head        = mq[0];
      m_upd_valid = 1'b1;
      m_upd_addr  = head.pc[9:2];
      m_upd_taken = rt;
      m_upd_cond  = rc;
      mis = (head.pred != rt);
`ifdef BRQ_TARGET_CHECK_EN
      if (rt && head.pred && head.target != rtgt) mis = 1'b1;
`endif
      if (mis) begin
        m_redirect   = rt ? rtgt : head.pc + 32'd4;
        m_flush_left = FLUSH_CYCLES;
        mq.delete();
        return;
      end
      void'(mq.pop_front());
    end
    if (do_push) begin
      nrec.pc     = ppc;
      nrec.pred   = ppred;
      nrec.target = ptgt;
      mq.push_back(nrec);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic compare_all(input string tag);
    int          sz;
    logic        m_flush;
    sz      = mq.size();
    m_flush = (m_flush_left > 0);
    check({tag, ".count"}, 32'(count), 32'(sz));
    check({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    check({tag, ".flush"}, 32'(flush), 32'(m_flush));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".upd_valid"}, 32'(upd_valid), 32'(m_upd_valid));
    if (m_upd_valid) begin
      check({tag, ".upd_addr"}, 32'(upd_addr), 32'(m_upd_addr));
      check({tag, ".upd_taken"}, 32'(upd_taken), 32'(m_upd_taken));
      check({tag, ".upd_is_cond"}, 32'(upd_is_cond), 32'(m_upd_cond));
    end
    if (m_flush) begin
      check({tag, ".redirect_pc"}, redirect_pc, m_redirect);
    end
  endtask

  // One clock cycle: drive, clock the design and the model, then compare.
  task automatic cycle(input string tag, input logic p, input logic [31:0] ppc,
                       input logic ppred, input logic [31:0] ptgt,
                       input logic r, input logic rt, input logic [31:0] rtgt,
                       input logic rc);
    push        = p;
    push_pc     = ppc;
    push_pred   = ppred;
    push_target = ptgt;
    resolve     = r;
    res_taken   = rt;
    res_target  = rtgt;
    res_is_cond = rc;
    @(posedge clk);
    model_step(p, ppc, ppred, ptgt, r, rt, rtgt, rc);
    #1;
    compare_all(tag);
  endtask

  task automatic do_push(input string tag, input logic [31:0] pc,
                         input logic pred, input logic [31:0] tgt);
    cycle(tag, 1'b1, pc, pred, tgt, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_resolve(input string tag, input logic taken,
                            input logic [31:0] tgt, input logic cond);
    cycle(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, taken, tgt, cond);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    push = 1'b0; push_pc = '0; push_pred = 1'b0; push_target = '0;
    resolve = 1'b0; res_taken = 1'b0; res_target = '0; res_is_cond = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    compare_all("reset");
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic        rp, rr, rt, rc, rpred;
    logic [31:0] rpc, rtg, rrt;

    // Reset state, including the fields compare_all does not cover.
    do_reset();
    check("reset.upd_addr", 32'(upd_addr), 32'h0);
    check("reset.upd_taken", 32'(upd_taken), 32'h0);
    check("reset.upd_is_cond", 32'(upd_is_cond), 32'h0);
    check("reset.redirect_pc", redirect_pc, 32'h0);

    // Correct not-taken prediction produces an update and no flush.
    do_push("t36.push", 32'h100, 1'b0, 32'h0);
    do_resolve("t36.res", 1'b0, 32'h0, 1'b1);
    check("t36.flush", 32'(flush), 32'h0);
    check("t36.upd_valid", 32'(upd_valid), 32'h1);
    check("t36.upd_addr", 32'(upd_addr), 32'h40);
    check("t36.upd_taken", 32'(upd_taken), 32'h0);

    // Predicted not-taken but taken: flush to the actual target.
    do_push("t37.push", 32'h200, 1'b0, 32'h0);
    do_resolve("t37.res", 1'b1, 32'h300, 1'b1);
    check("t37.flush1", 32'(flush), 32'h1);
    check("t37.redirect", redirect_pc, 32'h300);
    check("t37.count", 32'(count), 32'h0);
    check("t37.upd_valid", 32'(upd_valid), 32'h1);
    idle("t37.f2");
    check("t37.flush2", 32'(flush), 32'h1);
    check("t37.redirect2", redirect_pc, 32'h300);
    idle("t37.f3");
    check("t37.flush_end", 32'(flush), 32'h0);

    // Predicted taken but not taken: flush to the fall-through PC.
    do_push("t38.push", 32'h400, 1'b1, 32'h500);
    do_resolve("t38.res", 1'b0, 32'h0, 1'b1);
    check("t38.redirect", redirect_pc, 32'h404);
    idle("t38.f2");
    idle("t38.f3");

    // Traffic during a flush is ignored and does not set err.
    do_push("flushign.push", 32'h600, 1'b0, 32'h0);
    do_resolve("flushign.res", 1'b1, 32'h700, 1'b0);
    do_push("flushign.p1", 32'h800, 1'b0, 32'h0);
    do_resolve("flushign.r1", 1'b0, 32'h0, 1'b0);
    check("flushign.err", 32'(err), 32'h0);

    // Fill, overflow, then push and resolve together while full.
    for (int i = 0; i < 5; i++) begin
      do_push("t39.push", 32'h1000 + 32'(i) * 4, 1'b0, 32'h0);
      if (i == 3) check("t39.full4", 32'(full), 32'h1);
    end
    check("t39.count", 32'(count), 32'h4);
    check("t39.err", 32'(err), 32'h1);
    cycle("t39.both", 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t39.count_both", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) do_resolve("t39.drain", 1'b0, 32'h0, 1'b0);
    do_resolve("underflow", 1'b0, 32'h0, 1'b0);

    // Taken-to-taken with a different target.
    do_reset();
    do_push("t40.push", 32'h480, 1'b1, 32'h500);
    do_resolve("t40.res", 1'b1, 32'h600, 1'b1);
`ifdef BRQ_TARGET_CHECK_EN
    check("t40.flush", 32'(flush), 32'h1);
    check("t40.redirect", redirect_pc, 32'h600);
`else
    check("t40.flush", 32'(flush), 32'h0);
`endif
    idle("t40.i1");
    idle("t40.i2");

    // Random phase. Resolutions mostly follow the prediction so that the
    // queue actually fills.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rp    = ($urandom_range(0, 9) < 6);
      rr    = ($urandom_range(0, 9) < 4);
      rpred = 1'(($urandom() & 1));
      rpc   = $urandom() & 32'hFFFF_FFFC;
      rtg   = $urandom() & 32'hFFFF_FFFC;
      rc    = 1'(($urandom() & 1));
      if (mq.size() > 0) begin
        rt  = ($urandom_range(0, 7) == 0) ? !mq[0].pred : mq[0].pred;
        rrt = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                          : mq[0].target;
      end else begin
        rt  = 1'(($urandom() & 1));
        rrt = $urandom() & 32'hFFFF_FFFC;
      end
      cycle("rand", rp, rpc, rpred, rtg, rr, rt, rrt, rc);
    end

    // Reset in the first flush cycle aborts the flush at once.
    do_reset();
    do_push("t41.push", 32'h900, 1'b0, 32'h0);
    do_resolve("t41.res", 1'b1, 32'hA00, 1'b1);
    check("t41.flush_before", 32'(flush), 32'h1);
    rst = 1'b1;
    #1;
    model_reset();
    check("t41.flush_async", 32'(flush), 32'h0);
    check("t41.err", 32'(err), 32'h0);
    check("t41.count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_push("t41.run_push", 32'hB00, 1'b0, 32'h0);
    check("t41.run_count", 32'(count), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
